// File: rtl/serial_adder_4bit.sv
// Bit-serial unsigned adder: one full adder, a carry flip-flop and shift
// registers process the operands LSB first, one bit per clock. The result
// registers update only when the last bit has been added, so partial sums
// are never visible on the outputs.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | adding one bit per clock, counter selects the bit
// DONE  | result just loaded, done pulse; start here chains a new add
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_sum_sr_nxt;

    // Single full adder working on the current LSBs of the operand shifters.
    assign w_sum_bit    = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_nxt  = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
    assign w_sum_sr_nxt = {w_sum_bit, r_sum_sr[WIDTH-1:1]};
    assign w_last       = (r_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath: operand latch, per-bit add/shift, result load on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_sum_sr <= '0;
            r_carry  <= cin;
        end else if (w_shift) begin
            r_cnt    <= r_cnt + CW'(1);
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_sum_sr <= w_sum_sr_nxt;
            r_carry  <= w_carry_nxt;
            if (w_last) begin
                r_sum  <= w_sum_sr_nxt;
                r_cout <= w_carry_nxt;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed bench for serial_adder_4bit: hand-computed vectors, outputs
// sampled 1 time unit after each rising edge.
module tb_serial_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] prev_sum;
    logic       prev_cout;

    serial_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated addition: start pulse at edge N, done expected after N+4.
    task automatic run_add(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                           input logic tc, input logic [3:0] es, input logic ec);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 8'(busy), 8'd1);
            chk({tag, "_done_early"}, 8'(done), 8'd0);
            chk({tag, "_sum_hold"}, 8'(sum), 8'(prev_sum));
            chk({tag, "_cout_hold"}, 8'(cout), 8'(prev_cout));
            tick();
        end
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_busy_off"}, 8'(busy), 8'd0);
        chk({tag, "_sum"}, 8'(sum), 8'(es));
        chk({tag, "_cout"}, 8'(cout), 8'(ec));
        tick();
        chk({tag, "_done_clr"}, 8'(done), 8'd0);
        chk({tag, "_sum_keep"}, 8'(sum), 8'(es));
        prev_sum  = es;
        prev_cout = ec;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sum", 8'(sum), 8'd0);
        chk("rst_cout", 8'(cout), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 8'(busy), 8'd0);
        prev_sum = 4'd0; prev_cout = 1'b0;

        // 3+4 = 7, then carry cases 16 and 31.
        run_add("add3p4", 4'd3, 4'd4, 1'b0, 4'd7, 1'b0);
        run_add("add9p7", 4'd9, 4'd7, 1'b0, 4'd0, 1'b1);
        run_add("add15p15c", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
        run_add("add10p5c", 4'd10, 4'd5, 1'b1, 4'd0, 1'b1);

        // 5+2 with operand changes and a stray start during SHIFT.
        a = 4'd5; b = 4'd2; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; a = 4'd0; b = 4'd0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            chk("ign_done", 8'(done), (k == 4) ? 8'd1 : 8'd0);
            chk("ign_busy", 8'(busy), (k < 4) ? 8'd1 : 8'd0);
            if (k == 4) begin
                chk("ign_sum", 8'(sum), 8'd7);
                chk("ign_cout", 8'(cout), 8'd0);
            end
            tick();
        end

        // start held high: 1+1 repeats with a 5-clock period.
        a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("b2b_done", 8'(done), ((k % 5) == 4) ? 8'd1 : 8'd0);
            chk("b2b_busy", 8'(busy), ((k % 5) == 4) ? 8'd0 : 8'd1);
            chk("b2b_sum", 8'(sum), (k < 4) ? 8'd7 : 8'd2);
            chk("b2b_cout", 8'(cout), 8'd0);
        end
        start = 1'b0;
        tick();
        chk("b2b_idle_busy", 8'(busy), 8'd0);
        chk("b2b_idle_done", 8'(done), 8'd0);

        // Reset mid-operation aborts 8+8.
        a = 4'd8; b = 4'd8; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 8'(sum), 8'd0);
        chk("abort_cout", 8'(cout), 8'd0);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_done", 8'(done), 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("inrst_done", 8'(done), 8'd0);
            chk("inrst_busy", 8'(busy), 8'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_done", 8'(done), 8'd0);
            chk("post_sum", 8'(sum), 8'd0);
            chk("post_cout", 8'(cout), 8'd0);
        end
        prev_sum = 4'd0; prev_cout = 1'b0;
        run_add("add6p6c", 4'd6, 4'd6, 1'b1, 4'd13, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
